// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks the next fetch PC from sequential, branch or
// jump sources, paces fetch against if_ready, and buffers one stalled redirect.
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               INC          = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             if_ready,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_pc,
  input  logic [WIDTH-1:0] br_simm,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  output logic             if_req,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             redirect
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_WAIT} state_t;

  state_t           state, state_next;
  logic             pend_v, pend_v_next;
  logic [WIDTH-1:0] pend_pc, pend_pc_next;
  logic [WIDTH-1:0] pc_next;
  logic             redirect_next;

  logic             adv;
  logic             arrive;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] arrive_pc;

  assign pc_plus   = pc + WIDTH'(INC);
  assign br_target = br_pc + br_simm;
  assign if_req    = (state != S_BOOT) && !hold;
  assign adv       = if_req && if_ready;

  // Jump beats branch whenever both resolve in the same cycle.
  assign arrive    = jmp || br_taken;
  assign arrive_pc = jmp ? jmp_target : br_target;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would infer a latch.
    state_next    = state;
    pc_next       = pc;
    pend_v_next   = pend_v;
    pend_pc_next  = pend_pc;
    redirect_next = 1'b0;

    case (state)
      S_BOOT:  state_next = S_RUN;
      default: state_next = adv ? S_RUN : S_WAIT;
    endcase

    if (adv) begin
      redirect_next = pend_v || arrive;
      pend_v_next   = 1'b0;
      if (pend_v)      pc_next = pend_pc;
      else if (arrive) pc_next = arrive_pc;
      else             pc_next = pc_plus;
    end else if (arrive && !pend_v) begin
      // A newer redirect while one is buffered is dropped: the older one is
      // architecturally first.
      pend_v_next  = 1'b1;
      pend_pc_next = arrive_pc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_BOOT;
      pc       <= RESET_VECTOR;
      redirect <= 1'b0;
      pend_v   <= 1'b0;
      // NOTE: pend_pc is only meaningful under pend_v, but it is a single
      // register (not a memory array), so resetting it is cheap and keeps X out.
      pend_pc  <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      redirect <= redirect_next;
      pend_v   <= pend_v_next;
      pend_pc  <= pend_pc_next;
    end
  end

endmodule
